axi_lite_mem_slave: RTL

- Synthesizable AXI-lite-subset responder; the memory side of the CPU's AXI master port.
- Replaces the behavioural stub with a real word-addressed RAM that honours write strobes and full valid/ready handshakes.
- Channels: AW, W, B, AR, R. No resp codes, IDs or bursts.
- Sits between cpu_top's AXI port and the system/test harness.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/byte_en_ram.sv | 42 ++++
 rtl/axi_lite_mem_slave.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and helpers for the AXI-lite memory responder
package axi_lite_pkg;

    localparam int XLEN_DEFAULT = 32;

    function automatic int strb_width(input int xlen);
        return xlen / 8;
    endfunction

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // off is addr - base already wrapped to XLEN bits, so addresses below base land far out of range
    function automatic logic addr_in_range(input logic [63:0] off, input int depth);
        return off < (64'(depth) << 2);
    endfunction

endpackage

// File: rtl/byte_en_ram.sv
// rtl/byte_en_ram.sv - DEPTH x XLEN RAM, byte-enable write port, registered read-first read port
module byte_en_ram
    import axi_lite_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH),
    localparam int SW   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [SW-1:0]   wstrb,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < SW; k++) begin
                if (wstrb[k]) begin
                    mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Sampling mem on the same edge as a write returns the old word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI-lite subset responder backed by a word-addressed byte-enable RAM
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   axi_awaddr,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [XLEN-1:0]   axi_wdata,
    input  logic [XLEN/8-1:0] axi_wstrb,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic [XLEN-1:0]   axi_araddr,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [XLEN-1:0]   axi_rdata,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [15:0]       oor_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = strb_width(XLEN);

    logic            aw_full, w_full, bvalid_q, rd_zero_q;
    logic [XLEN-1:0] aw_addr_q, w_data_q;
    logic [SW-1:0]   w_strb_q;
    logic [15:0]     oor_q;
    rd_state_e       rd_state, rd_state_nxt;

    logic            aw_hs, w_hs, b_hs, ar_hs, commit;
    logic [XLEN-1:0] wr_off, rd_off, ram_rdata;
    logic            wr_in_range, rd_in_range;
    logic [1:0]      oor_inc;
    logic [16:0]     oor_sum;

    assign axi_awready = !rst && !aw_full;
    assign axi_wready  = !rst && !w_full;
    assign axi_bvalid  = bvalid_q;
    assign oor_count   = oor_q;

    assign aw_hs  = axi_awvalid && axi_awready;
    assign w_hs   = axi_wvalid && axi_wready;
    assign b_hs   = bvalid_q && axi_bready;
    assign ar_hs  = axi_arvalid && axi_arready;
    assign commit = aw_full && w_full && !bvalid_q;

    assign wr_off      = aw_addr_q - BASE_ADDR;
    assign rd_off      = axi_araddr - BASE_ADDR;
    assign wr_in_range = addr_in_range(64'(wr_off), DEPTH);
    assign rd_in_range = addr_in_range(64'(rd_off), DEPTH);

    // Buffers clear on commit; they cannot refill that cycle because ready is low while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axi_awaddr;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= axi_wdata;
                w_strb_q <= axi_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign oor_inc = {1'b0, commit && !wr_in_range} + {1'b0, ar_hs && !rd_in_range};
    assign oor_sum = {1'b0, oor_q} + {15'd0, oor_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q     <= '0;
            rd_zero_q <= 1'b0;
            rd_state  <= R_IDLE;
        end else begin
            oor_q    <= oor_sum[16] ? 16'hFFFF : oor_sum[15:0];
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rd_zero_q <= !rd_in_range;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        axi_arready  = 1'b0;
        axi_rvalid   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                axi_arready = !rst;
                if (axi_arvalid && !rst) begin
                    rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                if (axi_rready) begin
                    rd_state_nxt = R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign axi_rdata = rd_zero_q ? '0 : ram_rdata;

    byte_en_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && wr_in_range),
        .waddr (wr_off[AW+1:2]),
        .wstrb (w_strb_q),
        .wdata (w_data_q),
        .re    (ar_hs),
        .raddr (rd_off[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule
